// File: rtl/count_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : count_seq_checker
// Purpose  : Watches a sampled counter, locks once it increments cleanly and
//            counts breaks in the sequence after lock.
// Revision : 1.0 - initial release
// ============================================================================
module count_seq_checker #(
    parameter int WIDTH     = 8,
    parameter int LOCK_CNT  = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_en,
    input  logic [WIDTH-1:0]     cnt_in,
    input  logic                 clear,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [WIDTH-1:0]     last_bad,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACQUIRE = 2'b01,
        LOCKED  = 2'b10
    } state_t;

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_CNT);

    state_t               r_state, w_state_nxt;
    logic [WIDTH-1:0]     r_prev, w_prev_nxt;
    logic [WIDTH-1:0]     r_last_bad, w_last_bad_nxt;
    logic [3:0]           r_run, w_run_nxt;
    logic                 r_locked, w_locked_nxt;
    logic                 r_err_pulse, w_err_pulse_nxt;
    logic [ERR_CNT_W-1:0] r_err_count, w_err_count_nxt;
    logic [ERR_CNT_W-1:0] w_err_base;
    logic [WIDTH-1:0]     w_expect;
    logic                 w_match;

    // Clear applies first so a coincident error is counted on top of zero.
    assign w_err_base = clear ? '0 : r_err_count;
    assign w_expect   = r_prev + WIDTH'(1);
    assign w_match    = (cnt_in == w_expect);

    always_comb begin
        w_state_nxt     = r_state;
        w_prev_nxt      = r_prev;
        w_run_nxt       = r_run;
        w_locked_nxt    = r_locked;
        w_err_pulse_nxt = 1'b0;
        w_err_count_nxt = w_err_base;
        w_last_bad_nxt  = clear ? '0 : r_last_bad;

        case (r_state)
            IDLE: begin
                if (sample_en) begin
                    w_prev_nxt  = cnt_in;
                    w_run_nxt   = 4'd0;
                    w_state_nxt = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (sample_en) begin
                    w_prev_nxt = cnt_in;
                    if (w_match) begin
                        w_run_nxt = r_run + 4'd1;
                        if (r_run + 4'd1 == LOCK_TARGET) begin
                            w_state_nxt  = LOCKED;
                            w_locked_nxt = 1'b1;
                        end
                    end else begin
                        w_run_nxt = 4'd0;
                    end
                end
            end
            LOCKED: begin
                if (sample_en) begin
                    w_prev_nxt = cnt_in;
                    if (!w_match) begin
                        w_err_pulse_nxt = 1'b1;
                        w_err_count_nxt = (w_err_base == '1) ? w_err_base
                                                             : w_err_base + ERR_CNT_W'(1);
                        w_last_bad_nxt  = cnt_in;
                        w_locked_nxt    = 1'b0;
                        w_state_nxt     = ACQUIRE;
                        w_run_nxt       = 4'd0;
                    end
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_locked_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_prev      <= '0;
            r_run       <= 4'd0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
            r_last_bad  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev      <= w_prev_nxt;
            r_run       <= w_run_nxt;
            r_locked    <= w_locked_nxt;
            r_err_pulse <= w_err_pulse_nxt;
            r_err_count <= w_err_count_nxt;
            r_last_bad  <= w_last_bad_nxt;
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign last_bad  = r_last_bad;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_count_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_seq_checker
// Purpose  : Directed scoreboard bench for count_seq_checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_seq_checker;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_ACQ  = 2'b01;
    localparam logic [1:0] ST_LOCK = 2'b10;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       sample_en = 1'b0;
    logic       clear     = 1'b0;
    logic [7:0] cnt_in    = 8'h00;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic [7:0] last_bad;
    logic [1:0] state;

    count_seq_checker #(
        .WIDTH     (8),
        .LOCK_CNT  (4),
        .ERR_CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .cnt_in    (cnt_in),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .last_bad  (last_bad),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       lk;
        logic       pl;
        logic [7:0] ec;
        logic [7:0] lb;
        logic [1:0] st;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_ec   = 8'h00;
    logic [7:0] m_lb   = 8'h00;
    logic [7:0] m_prev = 8'h00;

    task automatic cmp(input string tag, input string fld,
                       input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, fld, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, then compare.
    task automatic step(input string tag, input logic r, input logic en,
                        input logic [7:0] v, input logic clr,
                        input logic lk, input logic pl, input logic [1:0] st);
        exp_t e;
        @(negedge clk);
        rst       = r;
        sample_en = en;
        cnt_in    = v;
        clear     = clr;
        sb.push_back(exp_t'{lk, pl, m_ec, m_lb, st});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            cmp(tag, "locked",    {7'd0, locked},    {7'd0, e.lk});
            cmp(tag, "err_pulse", {7'd0, err_pulse}, {7'd0, e.pl});
            cmp(tag, "err_count", err_count,         e.ec);
            cmp(tag, "last_bad",  last_bad,          e.lb);
            cmp(tag, "state",     {6'd0, state},     {6'd0, e.st});
        end
    endtask

    // From IDLE: first sample loads, four matches lock.
    task automatic lock_in(input string tag, input logic [7:0] base);
        for (int i = 0; i <= 4; i++) begin
            step(tag, 1'b0, 1'b1, 8'(base + i), 1'b0,
                 (i == 4), 1'b0, (i == 4) ? ST_LOCK : ST_ACQ);
        end
        m_prev = 8'(base + 4);
    endtask

    // From LOCKED: a break at g, then g+1..g+4 relock.
    task automatic glitch_relock(input string tag, input logic [7:0] g);
        m_ec = (m_ec == 8'hFF) ? m_ec : m_ec + 8'h01;
        m_lb = g;
        step(tag, 1'b0, 1'b1, g, 1'b0, 1'b0, 1'b1, ST_ACQ);
        for (int i = 1; i <= 4; i++) begin
            step(tag, 1'b0, 1'b1, 8'(g + i), 1'b0,
                 (i == 4), 1'b0, (i == 4) ? ST_LOCK : ST_ACQ);
        end
        m_prev = 8'(g + 4);
    endtask

    initial begin
        #500000;
        $error("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        step("reset",       1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, ST_IDLE);
        step("rst_override", 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, ST_IDLE);

        lock_in("lockin", 8'h00);
        step("lockin5", 1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 1'b0, ST_LOCK);
        step("idle_hold", 1'b0, 1'b0, 8'h99, 1'b0, 1'b1, 1'b0, ST_LOCK);

        for (int v = 6; v <= 16; v++)
            step("run_to_10", 1'b0, 1'b1, 8'(v), 1'b0, 1'b1, 1'b0, ST_LOCK);
        glitch_relock("glitch13", 8'h13);

        // Repeated value breaks lock; an ACQUIRE mismatch restarts the run.
        m_ec = 8'h02;
        m_lb = 8'h17;
        step("repeat17", 1'b0, 1'b1, 8'h17, 1'b0, 1'b0, 1'b1, ST_ACQ);
        step("acq18",    1'b0, 1'b1, 8'h18, 1'b0, 1'b0, 1'b0, ST_ACQ);
        step("acq19",    1'b0, 1'b1, 8'h19, 1'b0, 1'b0, 1'b0, ST_ACQ);
        step("acq_miss", 1'b0, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, ST_ACQ);
        step("acq31",    1'b0, 1'b1, 8'h31, 1'b0, 1'b0, 1'b0, ST_ACQ);
        step("acq32",    1'b0, 1'b1, 8'h32, 1'b0, 1'b0, 1'b0, ST_ACQ);
        step("acq33",    1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, ST_ACQ);
        step("relock34", 1'b0, 1'b1, 8'h34, 1'b0, 1'b1, 1'b0, ST_LOCK);

        m_ec = 8'h01;
        m_lb = 8'h42;
        step("clr_collide", 1'b0, 1'b1, 8'h42, 1'b1, 1'b0, 1'b1, ST_ACQ);
        step("acq43",       1'b0, 1'b1, 8'h43, 1'b0, 1'b0, 1'b0, ST_ACQ);
        step("acq44",       1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, ST_ACQ);
        step("acq45",       1'b0, 1'b1, 8'h45, 1'b0, 1'b0, 1'b0, ST_ACQ);
        step("relock46",    1'b0, 1'b1, 8'h46, 1'b0, 1'b1, 1'b0, ST_LOCK);
        m_ec = 8'h00;
        m_lb = 8'h00;
        step("clr_only",    1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, ST_LOCK);

        glitch_relock("err_a", 8'h60);
        glitch_relock("err_b", 8'h70);
        glitch_relock("err_c", 8'h80);
        m_ec = 8'h00;
        m_lb = 8'h00;
        step("rst_mid", 1'b1, 1'b1, 8'h85, 1'b0, 1'b0, 1'b0, ST_IDLE);
        lock_in("relockin", 8'h00);
        step("relockin5", 1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 1'b0, ST_LOCK);

        step("wrap_rst", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, ST_IDLE);
        lock_in("wrap_lock", 8'hF9);
        step("wrapFE", 1'b0, 1'b1, 8'hFE, 1'b0, 1'b1, 1'b0, ST_LOCK);
        step("wrapFF", 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, ST_LOCK);
        step("wrap00", 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, ST_LOCK);
        step("wrap01", 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, ST_LOCK);
        m_prev = 8'h01;

        for (int k = 0; k < 260; k++)
            glitch_relock("sat", 8'(m_prev + 8'h03));
        glitch_relock("sat_hold", 8'(m_prev + 8'h03));
        step("sat_idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, ST_LOCK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_seq_checker.md
COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk only.
REQ-002 Parameter WIDTH, default 8: width of the observed counter value.
REQ-003 Parameter LOCK_CNT, default 4, legal range 1..15: number of consecutive correct increments required to lock.
REQ-004 Parameter ERR_CNT_W, default 8: width of the error counter.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 sample_en  input  1  cnt_in is valid this cycle.
REQ-008 cnt_in  input  WIDTH  observed counter value.
REQ-009 clear  input  1  clears err_count and last_bad.
REQ-010 locked  output  1  sequence verified as incrementing.
REQ-011 err_pulse  output  1  one-cycle strobe per detected break in a locked sequence.
REQ-012 err_count  output  ERR_CNT_W  saturating count of detected errors.
REQ-013 last_bad  output  WIDTH  cnt_in value of the most recent error.
REQ-014 state  output  2  FSM state: IDLE=00, ACQUIRE=01, LOCKED=10; 11 is unused.

Function
REQ-015 All outputs SHALL be registered; each output SHALL change only in the cycle after the causing sample.
REQ-016 When sample_en is 0, no internal state or output SHALL change, except that err_pulse SHALL be 0 and clear SHALL still take effect.
REQ-017 "Match" SHALL mean cnt_in == (prev + 1) mod 2^WIDTH, where prev is the last accepted sample; the wrap from all-ones to 0 SHALL be a match.
REQ-018 A repeated value (cnt_in == prev) SHALL be a mismatch.
REQ-019 Every accepted sample SHALL update prev to cnt_in.
REQ-020 IDLE: the first sample SHALL load prev, clear the run counter and move the FSM to ACQUIRE; no comparison is made on this sample.
REQ-021 ACQUIRE, on a match: the run counter SHALL increment; when it reaches LOCK_CNT, the FSM SHALL move to LOCKED and locked SHALL go to 1.
REQ-022 ACQUIRE, on a mismatch: the run counter SHALL reset to 0, the FSM SHALL stay in ACQUIRE, and no error SHALL be counted.
REQ-023 LOCKED, on a match: the FSM SHALL remain in LOCKED.
REQ-024 LOCKED, on a mismatch: err_pulse SHALL be 1 for exactly one cycle, err_count SHALL increment, last_bad SHALL take cnt_in, locked SHALL go to 0, the FSM SHALL move to ACQUIRE, and the run counter SHALL reset to 0.
REQ-025 err_count SHALL saturate at all-ones and SHALL not wrap.
REQ-026 clear SHALL zero err_count and last_bad and SHALL not affect the FSM, prev or locked.
REQ-027 If clear coincides with an error, the result SHALL be err_count = 1 and last_bad = cnt_in (the error is counted after the clear).
REQ-028 Unused state encoding 11 SHALL recover to IDLE on the next clock.

Reset
REQ-029 While rst = 1 at a clock edge: state SHALL be IDLE, and locked, err_pulse, err_count, last_bad, prev and the run counter SHALL all be 0.
REQ-030 rst SHALL override sample_en and clear in the same cycle.
REQ-031 Reset mid-operation SHALL discard lock; the next sample after reset is treated as the first sample in IDLE.

Verification
REQ-032 Lock-in: after reset, samples 0x00..0x05, one per cycle -> locked rises the cycle after sample 0x04; err_count stays 0.
REQ-033 Wrap: while locked, samples 0xFE, 0xFF, 0x00, 0x01 -> no err_pulse and locked stays 1.
REQ-034 Glitch and relock: locked after 0x10, then 0x13, 0x14..0x17 -> err_pulse for one cycle, err_count = 1, last_bad = 0x13, locked = 0, then locked = 1 again the cycle after 0x17.
REQ-035 Saturation: 260 lock/glitch cycles with ERR_CNT_W = 8 -> err_count = 0xFF and holds there.
REQ-036 Clear collision: clear asserted in the same cycle as a locked mismatch on 0x42 -> err_count = 1 and last_bad = 0x42; clear alone afterwards -> both 0 and locked unchanged.
REQ-037 Reset mid-lock: rst pulsed for one cycle while locked with err_count = 3 -> all outputs 0 and state IDLE; lock-in then repeats per REQ-032.
